// File: rtl/mcu_ctrl.sv
// mcu_ctrl: fetch/decode/execute sequencer for the MCU core.
// Drives register-bank strobes, pc/imem_addr, dmem strobes and alu_op.
// Ports: clk, rst (async, active-high); opcode, imm, psr from the register bank;
// imem_addr; opcode/imm/acc/psr_update; acc_src; alu_op; dmem_addr/rd/wr;
// halted; trap.
// Optional build macro CTRL_TRAP_EN: illegal opcodes halt and raise trap.
module mcu_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 8,
  parameter int PC_WIDTH   = 8,
  parameter int APSR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] opcode,
  input  logic [INST_WIDTH-1:0] imm,
  input  logic [APSR_WIDTH-1:0] psr,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  opcode_update,
  output logic                  imm_update,
  output logic                  acc_update,
  output logic                  psr_update,
  output logic                  acc_src,
  output logic [2:0]            alu_op,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic                  dmem_rd,
  output logic                  dmem_wr,
  output logic                  halted,
  output logic                  trap
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWB,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;

  state_t state, state_n;

  logic [PC_WIDTH-1:0] pc, pc_n;
  logic [3:0]          cls;

  logic c_nop, c_ldi, c_ldm, c_stm;
  logic c_add, c_sub, c_and, c_or;
  logic c_jmp, c_jz, c_jc, c_hlt;
  logic two_word, legal;

  logic unused;

  assign cls = opcode[INST_WIDTH-1:INST_WIDTH-4];

  assign c_nop = (cls == 4'h0);
  assign c_ldi = (cls == 4'h1);
  assign c_ldm = (cls == 4'h2);
  assign c_stm = (cls == 4'h3);
  assign c_add = (cls == 4'h4);
  assign c_sub = (cls == 4'h5);
  assign c_and = (cls == 4'h6);
  assign c_or  = (cls == 4'h7);
  assign c_jmp = (cls == 4'h8);
  assign c_jz  = (cls == 4'h9);
  assign c_jc  = (cls == 4'hA);
  assign c_hlt = (cls == 4'hF);

  assign two_word = (cls >= 4'h1) && (cls <= 4'hA);
  assign legal    = two_word | c_nop | c_hlt;

  assign imem_addr = pc;
  assign dmem_addr = imm[DATA_WIDTH-1:0];

  assign unused = ^opcode[INST_WIDTH-5:0];

`ifdef CTRL_TRAP_EN
  logic trap_q, trap_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trap_q <= 1'b0;
    else if (trap_set)
      trap_q <= 1'b1;
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // Outputs are forced low while rst is held so that
  // nothing strobes between the rst edge and release.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    opcode_update = 1'b0;
    imm_update    = 1'b0;
    acc_update    = 1'b0;
    psr_update    = 1'b0;
    acc_src       = 1'b0;
    alu_op        = OP_PASS;
    dmem_rd       = 1'b0;
    dmem_wr       = 1'b0;
    halted        = 1'b0;
`ifdef CTRL_TRAP_EN
    trap_set      = 1'b0;
`endif
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          opcode_update = 1'b1;
          pc_n          = pc + 1'b1;
          state_n       = S_DECODE;
        end
        S_DECODE: begin
          if (two_word) begin
            imm_update = 1'b1;
            pc_n       = pc + 1'b1;
            state_n    = c_ldm ? S_MEMRD : S_EXEC;
          end else if (c_hlt) begin
            state_n = S_HALT;
          end else if (!legal) begin
`ifdef CTRL_TRAP_EN
            trap_set = 1'b1;
            state_n  = S_HALT;
`else
            state_n  = S_FETCH;
`endif
          end else begin
            state_n = S_FETCH;
          end
        end
        S_MEMRD: begin
          dmem_rd = 1'b1;
          state_n = S_MEMWB;
        end
        S_MEMWB: begin
          acc_src    = 1'b1;
          acc_update = 1'b1;
          psr_update = 1'b1;
          state_n    = S_FETCH;
        end
        S_EXEC: begin
          state_n = S_FETCH;
          unique case (1'b1)
            c_ldi: begin
              alu_op     = OP_PASS;
              acc_update = 1'b1;
              psr_update = 1'b1;
            end
            c_add: begin
              alu_op     = OP_ADD;
              acc_update = 1'b1;
              psr_update = 1'b1;
            end
            c_sub: begin
              alu_op     = OP_SUB;
              acc_update = 1'b1;
              psr_update = 1'b1;
            end
            c_and: begin
              alu_op     = OP_AND;
              acc_update = 1'b1;
              psr_update = 1'b1;
            end
            c_or: begin
              alu_op     = OP_OR;
              acc_update = 1'b1;
              psr_update = 1'b1;
            end
            c_stm: dmem_wr = 1'b1;
            c_jmp: pc_n = imm[PC_WIDTH-1:0];
            c_jz: begin
              if (psr[0])
                pc_n = imm[PC_WIDTH-1:0];
            end
            c_jc: begin
              if (psr[1])
                pc_n = imm[PC_WIDTH-1:0];
            end
            default: ;
          endcase
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule
